phy_tx_sched: RTL

- Two-lane scheduler ahead of the transmit serializer: shares one byte-wide link between lane 0 and lane 1 via bounded round-robin arbitration.
- After reset and link enable, sequences the link through a training phase of COM symbols, then enters ACTIVE.
- In ACTIVE it forwards one granted byte per clk_f cycle and inserts IDL symbols when neither lane has data.
- Its output feeds the parallel-to-serial stage clocked from clk_8f.

---
 rtl/phy_tx_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/phy_tx_sched.sv
// phy_tx_sched: two-lane scheduler in front of the transmit serializer.
//
// After link enable, the block emits TRAIN_LEN COM symbols. It then enters
// ACTIVE, where it forwards one byte per clk_f cycle from lane 0 or lane 1.
// Lanes are chosen by bounded round-robin: the preferred lane keeps the link
// for at most MAX_BURST consecutive grants while the other lane is waiting.
// When neither lane has data, the block sends IDL fill symbols. The
// registered outputs feed the parallel-to-serial stage that runs on clk_8f.
//
// Ports:
//   clk_f                 scheduler clock; all state changes on its rising edge
//   reset                 asynchronous, active-high reset
//   enable                link enable; when low, the link drops back to idle
//   data_in0/valid_in0    lane 0 byte and request
//   ready0                lane 0 byte accepted this cycle (combinational)
//   data_in1/valid_in1    lane 1 byte and request
//   ready1                lane 1 byte accepted this cycle (combinational)
//   data_out              byte or symbol to the serializer (registered)
//   valid_out             data_out carries lane data (registered)
//   k_char                data_out is a COM or IDL control symbol (registered)
//   lane_sel              source lane of the last lane byte (registered)
//   active                scheduler is in ACTIVE (registered)
module phy_tx_sched #(
    parameter int         TRAIN_LEN = 4,
    parameter logic [7:0] COM       = 8'hBC,
    parameter logic [7:0] IDL       = 8'h7C,
    parameter int         MAX_BURST = 4
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in0,
    input  logic       valid_in0,
    output logic       ready0,
    input  logic [7:0] data_in1,
    input  logic       valid_in1,
    output logic       ready1,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       k_char,
    output logic       lane_sel,
    output logic       active
);

    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    localparam logic [1:0] ST_IDLE_RST = 2'd0;
    localparam logic [1:0] ST_TRAIN    = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] train_cnt_q, train_cnt_d;
    logic          pref_q, pref_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          k_char_q, k_char_d;
    logic          lane_sel_q, lane_sel_d;
    logic          active_q, active_d;

    logic       gnt_any;
    logic       gnt_lane;
    logic       xfer;
    logic       other_valid;
    logic [7:0] gnt_data;

    // Grant goes to the preferred lane if it is requesting; otherwise it goes
    // to the other lane.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_lane = pref_q;
        if (pref_q ? valid_in1 : valid_in0) begin
            gnt_any  = 1'b1;
            gnt_lane = pref_q;
        end else if (pref_q ? valid_in0 : valid_in1) begin
            gnt_any  = 1'b1;
            gnt_lane = ~pref_q;
        end
    end

    assign xfer        = (state_q == ST_ACTIVE) && enable && gnt_any;
    assign other_valid = gnt_lane ? valid_in0 : valid_in1;
    assign gnt_data    = gnt_lane ? data_in1 : data_in0;

    // The reset term appears only on the handshake outputs. A requester must
    // see ready drop as soon as reset asserts. Its byte is lost because the
    // flops are being cleared at the same time.
    assign ready0 = xfer && !gnt_lane && !reset;
    assign ready1 = xfer &&  gnt_lane && !reset;

    always_comb begin
        // NOTE: every *_d gets a default before any branch, so no path can
        // leave a signal unassigned and infer a latch.
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        pref_d      = pref_q;
        burst_cnt_d = burst_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        k_char_d    = k_char_q;
        lane_sel_d  = lane_sel_q;
        active_d    = active_q;

        if (!enable || (state_q != ST_TRAIN && state_q != ST_ACTIVE)) begin
            // Link down, or in idle (an unused encoding is also treated as
            // idle). Everything goes back to its reset value.
            state_d     = (enable && state_q == ST_IDLE_RST) ? ST_TRAIN : ST_IDLE_RST;
            train_cnt_d = '0;
            pref_d      = 1'b0;
            burst_cnt_d = '0;
            data_out_d  = 8'h00;
            valid_out_d = 1'b0;
            k_char_d    = 1'b0;
            lane_sel_d  = 1'b0;
            active_d    = 1'b0;
        end else if (state_q == ST_TRAIN) begin
            data_out_d  = COM;
            k_char_d    = 1'b1;
            valid_out_d = 1'b0;
            if (train_cnt_q == TRAIN_LAST) begin
                state_d     = ST_ACTIVE;
                active_d    = 1'b1;
                train_cnt_d = '0;
            end else begin
                train_cnt_d = train_cnt_q + 1'b1;
            end
        end else begin
            active_d = 1'b1;
            if (xfer) begin
                data_out_d  = gnt_data;
                valid_out_d = 1'b1;
                k_char_d    = 1'b0;
                lane_sel_d  = gnt_lane;
                if (gnt_lane != pref_q) begin
                    // The preferred lane was idle, so the lane that got the
                    // grant becomes the preferred lane.
                    pref_d      = gnt_lane;
                    burst_cnt_d = '0;
                end else if (other_valid) begin
                    // Contention: after MAX_BURST grants in a row, hand
                    // preference to the other lane.
                    if (burst_cnt_q == BURST_LAST) begin
                        pref_d      = ~pref_q;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    burst_cnt_d = '0;
                end
            end else begin
                data_out_d  = IDL;
                valid_out_d = 1'b0;
                k_char_d    = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever order the
    // statements are in.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE_RST;
            train_cnt_q <= '0;
            pref_q      <= 1'b0;
            burst_cnt_q <= '0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            k_char_q    <= 1'b0;
            lane_sel_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            pref_q      <= pref_d;
            burst_cnt_q <= burst_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            k_char_q    <= k_char_d;
            lane_sel_q  <= lane_sel_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign k_char    = k_char_q;
    assign lane_sel  = lane_sel_q;
    assign active    = active_q;

endmodule
